ddr_axi_native_bridge: RTL and testbench

Downstream of the DDR write/read traffic generators. Accepts AXI-style AW/W/AR requests, arbitrates between them, and turns each beat into commands on the DDR controller's native app interface. Returns write responses on B and read data on R through a small read-return FIFO. Drives `ddr_ready` back upstream so traffic sources launch only when the bridge is idle and calibration is complete.

---
 rtl/ddr_axi_native_bridge.sv | 239 +++++++++++++++++++++++
 tb/tb_ddr_axi_native_bridge.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_axi_native_bridge.sv
// ddr_axi_native_bridge
//
// Converts AXI-style write (AW/W/B) and read (AR/R) bursts into single-beat
// commands on a DDR controller's native app interface. Writes stream straight
// through with zero added latency. Read returns are captured in a small FIFO,
// and issue is credit-limited so that FIFO can never overflow.
//
// Ports:
//   clk, rstn                 clock, synchronous active-low reset
//   aw*/w*/b*                 AXI-style write address / data / response
//   ar*/r*                    AXI-style read address / data
//   ddr_ready                 bridge idle and controller calibrated
//   init_calib_complete       controller calibration done
//   app_addr/cmd/cmd_en/rdy   native command port
//   app_wdf_*                 native write-data port
//   app_rd_data(_valid)       native read return (cannot be stalled)
module ddr_axi_native_bridge #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 128,
    parameter int STRB_W      = DATA_W / 8,
    parameter int RFIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rstn,

    input  logic [ADDR_W-1:0] awaddr,
    input  logic [7:0]        awlen,
    input  logic              awvalid,
    output logic              awready,

    input  logic [DATA_W-1:0] wdata,
    input  logic [STRB_W-1:0] wstrb,
    input  logic              wvalid,
    output logic              wready,

    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,

    input  logic [ADDR_W-1:0] araddr,
    input  logic [7:0]        arlen,
    input  logic              arvalid,
    output logic              arready,

    output logic [DATA_W-1:0] rdata,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready,

    output logic              ddr_ready,
    input  logic              init_calib_complete,

    output logic [ADDR_W-1:0] app_addr,
    output logic [2:0]        app_cmd,
    output logic              app_cmd_en,
    input  logic              app_rdy,

    output logic [DATA_W-1:0] app_wdf_data,
    output logic [STRB_W-1:0] app_wdf_mask,
    output logic              app_wdf_wren,
    output logic              app_wdf_end,
    input  logic              app_wdf_rdy,

    input  logic [DATA_W-1:0] app_rd_data,
    input  logic              app_rd_data_valid
);

    localparam int              PTR_W      = (RFIFO_DEPTH > 1) ? $clog2(RFIFO_DEPTH) : 1;
    localparam int              CNT_W      = PTR_W + 1;
    localparam logic [ADDR_W-1:0] BEAT_BYTES = ADDR_W'(DATA_W / 8);
    localparam logic [31:0]     DEPTH_U    = RFIFO_DEPTH;
    localparam logic [2:0]      CMD_WRITE  = 3'b000;
    localparam logic [2:0]      CMD_READ   = 3'b001;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR      = 2'd1,
        WR_RESP = 2'd2,
        RD      = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               last_wr_q;
    logic [ADDR_W-1:0]  beat_addr_q;
    logic [7:0]         beat_cnt_q;
    logic [8:0]         issued_q;
    logic [8:0]         popped_q;

    logic [DATA_W-1:0]  fifo_mem [RFIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   fifo_cnt_q;

    logic               idle_ok;
    logic               grant_wr, grant_rd;
    logic               aw_hs, ar_hs;
    logic               wr_beat;
    logic [8:0]         outstanding;
    logic               rd_cmd_req, rd_cmd_acc;
    logic               fifo_push, fifo_pop;
    logic               at_last_pop, last_pop;

    // Arbitration: a lone requester always wins; when both request, the
    // channel that did not go last wins, so neither side can starve.
    assign idle_ok  = (state_q == IDLE) & init_calib_complete & rstn;
    assign grant_wr = awvalid & (~arvalid | ~last_wr_q);
    assign grant_rd = arvalid & (~awvalid |  last_wr_q);
    assign aw_hs    = idle_ok & grant_wr;
    assign ar_hs    = idle_ok & grant_rd;

    assign wr_beat  = (state_q == WR) & wvalid & app_rdy & app_wdf_rdy;

    // beat_cnt holds arlen during a read. Outstanding counts commands issued
    // but not yet popped, so in-flight returns plus FIFO contents never exceed
    // the FIFO depth.
    assign outstanding = issued_q - popped_q;
    assign rd_cmd_req  = (state_q == RD) & (issued_q <= {1'b0, beat_cnt_q})
                       & ({23'd0, outstanding} < DEPTH_U);
    assign rd_cmd_acc  = rd_cmd_req & app_rdy;

    // Returns are only accepted while a read burst is live, so data still in
    // flight when reset hits is dropped.
    assign fifo_push   = app_rd_data_valid & (state_q == RD);
    assign rvalid      = (fifo_cnt_q != '0);
    assign rdata       = fifo_mem[rd_ptr_q];
    assign fifo_pop    = rvalid & rready;
    assign at_last_pop = (popped_q == {1'b0, beat_cnt_q});
    assign rlast       = rvalid & at_last_pop;
    assign last_pop    = fifo_pop & at_last_pop;

    assign app_addr     = beat_addr_q;
    assign app_wdf_data = wdata;
    assign app_wdf_mask = wstrb;

    always_ff @(posedge clk) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (aw_hs)      state_d = WR;
                else if (ar_hs) state_d = RD;
            end
            WR:      if (wr_beat && beat_cnt_q == 8'd0) state_d = WR_RESP;
            WR_RESP: if (bready) state_d = IDLE;
            RD:      if (last_pop) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        awready      = 1'b0;
        arready      = 1'b0;
        wready       = 1'b0;
        bvalid       = 1'b0;
        bresp        = 2'b00;
        app_cmd      = CMD_WRITE;
        app_cmd_en   = 1'b0;
        app_wdf_wren = 1'b0;
        app_wdf_end  = 1'b0;
        ddr_ready    = 1'b0;
        case (state_q)
            IDLE: begin
                awready   = aw_hs;
                arready   = ar_hs;
                ddr_ready = rstn & init_calib_complete;
            end
            WR: begin
                app_cmd      = CMD_WRITE;
                app_cmd_en   = wvalid;
                app_wdf_wren = wvalid;
                app_wdf_end  = 1'b1;
                wready       = app_rdy & app_wdf_rdy;
            end
            WR_RESP: begin
                bvalid = 1'b1;
            end
            RD: begin
                app_cmd    = CMD_READ;
                app_cmd_en = rd_cmd_req;
            end
            default: ;
        endcase
    end

    // Burst bookkeeping: address/length capture on grant, then per-beat
    // address advance (wrapping at the top of the address space).
    always_ff @(posedge clk) begin
        if (!rstn) begin
            beat_addr_q <= '0;
            beat_cnt_q  <= '0;
            issued_q    <= '0;
            popped_q    <= '0;
            last_wr_q   <= 1'b0;
        end else begin
            if (aw_hs) begin
                beat_addr_q <= awaddr;
                beat_cnt_q  <= awlen;
            end else if (ar_hs) begin
                beat_addr_q <= araddr;
                beat_cnt_q  <= arlen;
                issued_q    <= '0;
                popped_q    <= '0;
            end else if (wr_beat) begin
                beat_addr_q <= beat_addr_q + BEAT_BYTES;
                beat_cnt_q  <= beat_cnt_q - 8'd1;
            end else if (rd_cmd_acc) begin
                beat_addr_q <= beat_addr_q + BEAT_BYTES;
                issued_q    <= issued_q + 9'd1;
            end
            if (fifo_pop) popped_q <= popped_q + 9'd1;
            if (state_q == WR_RESP && bready) last_wr_q <= 1'b1;
            else if (last_pop)                last_wr_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_push) fifo_mem[wr_ptr_q] <= app_rd_data;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (fifo_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (fifo_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + CNT_W'(1);
                2'b01:   fifo_cnt_q <= fifo_cnt_q - CNT_W'(1);
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_axi_native_bridge.sv
// Directed testbench for ddr_axi_native_bridge. A small controller model
// logs accepted commands, remembers written data and returns read data five
// cycles after each read command is accepted.
module tb_ddr_axi_native_bridge;

    logic         clk = 1'b0;
    logic         rstn;
    logic [31:0]  awaddr;
    logic [7:0]   awlen;
    logic         awvalid, awready;
    logic [127:0] wdata;
    logic [15:0]  wstrb;
    logic         wvalid, wready;
    logic [1:0]   bresp;
    logic         bvalid, bready;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic         arvalid, arready;
    logic [127:0] rdata;
    logic         rlast, rvalid, rready;
    logic         ddr_ready, init_calib_complete;
    logic [31:0]  app_addr;
    logic [2:0]   app_cmd;
    logic         app_cmd_en, app_rdy;
    logic [127:0] app_wdf_data;
    logic [15:0]  app_wdf_mask;
    logic         app_wdf_wren, app_wdf_end, app_wdf_rdy;
    logic [127:0] app_rd_data;
    logic         app_rd_data_valid;

    int vecs = 0;
    int miscompares = 0;

    localparam logic [127:0] WD0 = 128'h00000000_00000000_12345678_87654321;
    localparam logic [127:0] WD1 = 128'hCAFEF00D_0BADBEEF_13579BDF_2468ACE0;

    always #5 clk = ~clk;

    ddr_axi_native_bridge #(
        .ADDR_W(32), .DATA_W(128), .STRB_W(16), .RFIFO_DEPTH(16)
    ) dut (
        .clk(clk), .rstn(rstn),
        .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .ddr_ready(ddr_ready), .init_calib_complete(init_calib_complete),
        .app_addr(app_addr), .app_cmd(app_cmd), .app_cmd_en(app_cmd_en), .app_rdy(app_rdy),
        .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask), .app_wdf_wren(app_wdf_wren),
        .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
        .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid)
    );

    // Controller model
    typedef struct {
        logic [127:0] data;
        int           due;
    } ret_t;

    int           cyc = 0;
    logic [127:0] mem [logic [31:0]];
    logic [31:0]  cmd_addr_q [$];
    ret_t         ret_q [$];

    function automatic logic [127:0] rd_pattern(input logic [31:0] a);
        return {32'hDA7A5EED, a, ~a, a};
    endfunction

    initial begin
        app_rd_data_valid = 1'b0;
        app_rd_data       = '0;
        forever begin
            @(posedge clk);
            cyc++;
            if (rstn && app_cmd_en && app_rdy) begin
                if (app_cmd == 3'b000 && app_wdf_rdy && app_wdf_wren) begin
                    mem[app_addr] = app_wdf_data;
                    cmd_addr_q.push_back(app_addr);
                end else if (app_cmd == 3'b001) begin
                    ret_t r;
                    r.data = mem.exists(app_addr) ? mem[app_addr] : rd_pattern(app_addr);
                    r.due  = cyc + 5;
                    ret_q.push_back(r);
                    cmd_addr_q.push_back(app_addr);
                end
            end
            #1;
            if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
                app_rd_data_valid = 1'b1;
                app_rd_data       = ret_q[0].data;
                void'(ret_q.pop_front());
            end else begin
                app_rd_data_valid = 1'b0;
                app_rd_data       = '0;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rstn = 1'b0; init_calib_complete = 1'b1;
        awvalid = 1'b1; arvalid = 1'b1; wvalid = 1'b1;
        tick(); tick();
        #1;
        vecs++; if (awready !== 1'b0)    begin miscompares++; $display("[TB] FAIL reset_awready: got %b want 0", awready); end
        vecs++; if (arready !== 1'b0)    begin miscompares++; $display("[TB] FAIL reset_arready: got %b want 0", arready); end
        vecs++; if (wready !== 1'b0)     begin miscompares++; $display("[TB] FAIL reset_wready: got %b want 0", wready); end
        vecs++; if (bvalid !== 1'b0)     begin miscompares++; $display("[TB] FAIL reset_bvalid: got %b want 0", bvalid); end
        vecs++; if (rvalid !== 1'b0)     begin miscompares++; $display("[TB] FAIL reset_rvalid: got %b want 0", rvalid); end
        vecs++; if (rlast !== 1'b0)      begin miscompares++; $display("[TB] FAIL reset_rlast: got %b want 0", rlast); end
        vecs++; if (app_cmd_en !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_app_cmd_en: got %b want 0", app_cmd_en); end
        vecs++; if (app_wdf_wren !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_wdf_wren: got %b want 0", app_wdf_wren); end
        vecs++; if (app_wdf_end !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_wdf_end: got %b want 0", app_wdf_end); end
        vecs++; if (ddr_ready !== 1'b0)  begin miscompares++; $display("[TB] FAIL reset_ddr_ready: got %b want 0", ddr_ready); end
        vecs++; if (bresp !== 2'b00)     begin miscompares++; $display("[TB] FAIL reset_bresp: got %h want 0", bresp); end
        vecs++; if (app_cmd !== 3'b000)  begin miscompares++; $display("[TB] FAIL reset_app_cmd: got %h want 0", app_cmd); end
        awvalid = 1'b0; arvalid = 1'b0; wvalid = 1'b0;
        tick();
        rstn = 1'b1;
        #1;
        vecs++; if (ddr_ready !== 1'b1)  begin miscompares++; $display("[TB] FAIL reset_release_ddr_ready: got %b want 1", ddr_ready); end
        tick();
    endtask

    task automatic test_single_write();
        cmd_addr_q.delete();
        awaddr = 32'h0000F000; awlen = 8'd0; awvalid = 1'b1;
        wdata = WD0; wstrb = 16'h0000; app_rdy = 1'b0; app_wdf_rdy = 1'b1;
        #1;
        vecs++; if (awready !== 1'b1) begin miscompares++; $display("[TB] FAIL sw_awready: got %b want 1", awready); end
        tick();
        awvalid = 1'b0; wvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            vecs++; if (app_cmd_en !== 1'b1 || app_wdf_wren !== 1'b1) begin miscompares++; $display("[TB] FAIL sw_stall_en%0d: got %b%b want 11", i, app_cmd_en, app_wdf_wren); end
            vecs++; if (app_addr !== 32'h0000F000) begin miscompares++; $display("[TB] FAIL sw_stall_addr%0d: got %h want 0000f000", i, app_addr); end
            vecs++; if (app_wdf_data !== WD0) begin miscompares++; $display("[TB] FAIL sw_stall_data%0d: got %h want %h", i, app_wdf_data, WD0); end
            vecs++; if (wready !== 1'b0) begin miscompares++; $display("[TB] FAIL sw_stall_wready%0d: got %b want 0", i, wready); end
            vecs++; if (ddr_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL sw_busy_ddr_ready%0d: got %b want 0", i, ddr_ready); end
            tick();
        end
        app_rdy = 1'b1;
        #1;
        vecs++; if (wready !== 1'b1) begin miscompares++; $display("[TB] FAIL sw_wready: got %b want 1", wready); end
        vecs++; if (app_cmd !== 3'b000 || app_wdf_end !== 1'b1) begin miscompares++; $display("[TB] FAIL sw_cmd_end: got %h/%b want 0/1", app_cmd, app_wdf_end); end
        vecs++; if (app_wdf_mask !== 16'h0000) begin miscompares++; $display("[TB] FAIL sw_mask: got %h want 0000", app_wdf_mask); end
        tick();
        wvalid = 1'b0;
        #1;
        vecs++; if (bvalid !== 1'b1 || bresp !== 2'b00) begin miscompares++; $display("[TB] FAIL sw_bresp: got bvalid=%b bresp=%h want 1/0", bvalid, bresp); end
        vecs++; if (app_cmd_en !== 1'b0) begin miscompares++; $display("[TB] FAIL sw_cmd_en_after: got %b want 0", app_cmd_en); end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        #1;
        vecs++; if (bvalid !== 1'b0 || ddr_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL sw_idle: got bvalid=%b ddr_ready=%b want 0/1", bvalid, ddr_ready); end
        vecs++; if (cmd_addr_q.size() != 1) begin miscompares++; $display("[TB] FAIL sw_cmd_count: got %0d want 1", cmd_addr_q.size()); end
        else begin
            vecs++; if (cmd_addr_q[0] !== 32'h0000F000) begin miscompares++; $display("[TB] FAIL sw_cmd_addr: got %h want 0000f000", cmd_addr_q[0]); end
        end
        tick();
    endtask

    task automatic test_single_read();
        cmd_addr_q.delete();
        araddr = 32'h0000F000; arlen = 8'd0; arvalid = 1'b1; rready = 1'b1;
        #1;
        vecs++; if (arready !== 1'b1 || awready !== 1'b0) begin miscompares++; $display("[TB] FAIL sr_arready: got ar=%b aw=%b want 1/0", arready, awready); end
        tick();
        arvalid = 1'b0;
        #1;
        vecs++; if (app_cmd_en !== 1'b1 || app_cmd !== 3'b001 || app_addr !== 32'h0000F000) begin miscompares++; $display("[TB] FAIL sr_cmd: got en=%b cmd=%h addr=%h want 1/1/0000f000", app_cmd_en, app_cmd, app_addr); end
        for (int c = 0; c < 30; c++) begin
            if (rvalid) break;
            tick(); #1;
        end
        vecs++; if (rvalid !== 1'b1) begin miscompares++; $display("[TB] FAIL sr_rvalid_timeout: got %b want 1", rvalid); end
        vecs++; if (rdata !== WD0) begin miscompares++; $display("[TB] FAIL sr_rdata: got %h want %h", rdata, WD0); end
        vecs++; if (rlast !== 1'b1) begin miscompares++; $display("[TB] FAIL sr_rlast: got %b want 1", rlast); end
        tick(); #1;
        vecs++; if (rvalid !== 1'b0 || ddr_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL sr_idle: got rvalid=%b ddr_ready=%b want 0/1", rvalid, ddr_ready); end
        vecs++; if (cmd_addr_q.size() != 1) begin miscompares++; $display("[TB] FAIL sr_cmd_count: got %0d want 1", cmd_addr_q.size()); end
        tick();
    endtask

    task automatic test_arbitration();
        awaddr = 32'h00000100; awlen = 8'd0; araddr = 32'h00000100; arlen = 8'd0;
        awvalid = 1'b1; arvalid = 1'b1; app_rdy = 1'b1; rready = 1'b1;
        #1;
        vecs++; if (awready !== 1'b1 || arready !== 1'b0) begin miscompares++; $display("[TB] FAIL arb_first: got aw=%b ar=%b want 1/0", awready, arready); end
        tick();
        awvalid = 1'b0; wvalid = 1'b1; wdata = WD1; wstrb = 16'h0000;
        #1;
        vecs++; if (arready !== 1'b0 || app_cmd_en !== 1'b1) begin miscompares++; $display("[TB] FAIL arb_wr_busy: got ar=%b en=%b want 0/1", arready, app_cmd_en); end
        tick();
        wvalid = 1'b0; bready = 1'b1;
        tick();
        bready = 1'b0; awvalid = 1'b1;
        #1;
        vecs++; if (arready !== 1'b1 || awready !== 1'b0) begin miscompares++; $display("[TB] FAIL arb_second: got ar=%b aw=%b want 1/0", arready, awready); end
        tick();
        awvalid = 1'b0; arvalid = 1'b0;
        #1;
        for (int c = 0; c < 30; c++) begin
            if (rvalid) break;
            tick(); #1;
        end
        vecs++; if (rvalid !== 1'b1 || rdata !== WD1) begin miscompares++; $display("[TB] FAIL arb_rdata: got v=%b %h want 1 %h", rvalid, rdata, WD1); end
        tick(); #1;
        vecs++; if (ddr_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL arb_idle: got %b want 1", ddr_ready); end
        tick();
    endtask

    task automatic test_read_burst();
        logic [127:0] exp_d;
        int k;
        cmd_addr_q.delete();
        araddr = 32'h0000F000; arlen = 8'd19; arvalid = 1'b1; rready = 1'b0; app_rdy = 1'b1;
        #1;
        vecs++; if (arready !== 1'b1) begin miscompares++; $display("[TB] FAIL rb_arready: got %b want 1", arready); end
        tick();
        arvalid = 1'b0;
        for (int c = 0; c < 40; c++) tick();
        #1;
        vecs++; if (cmd_addr_q.size() != 16) begin miscompares++; $display("[TB] FAIL rb_credit_cmds: got %0d want 16", cmd_addr_q.size()); end
        vecs++; if (app_cmd_en !== 1'b0) begin miscompares++; $display("[TB] FAIL rb_credit_en: got %b want 0", app_cmd_en); end
        vecs++; if (rvalid !== 1'b1) begin miscompares++; $display("[TB] FAIL rb_fifo_full_rvalid: got %b want 1", rvalid); end
        rready = 1'b1;
        k = 0;
        for (int c = 0; c < 200 && k < 20; c++) begin
            if (rvalid) begin
                exp_d = (k == 0) ? WD0 : rd_pattern(32'h0000F000 + 32'(k * 16));
                vecs++; if (rdata !== exp_d) begin miscompares++; $display("[TB] FAIL rb_rdata%0d: got %h want %h", k, rdata, exp_d); end
                vecs++; if (rlast !== (k == 19)) begin miscompares++; $display("[TB] FAIL rb_rlast%0d: got %b want %b", k, rlast, (k == 19)); end
                k++;
            end
            tick(); #1;
        end
        vecs++; if (k != 20) begin miscompares++; $display("[TB] FAIL rb_beat_count: got %0d want 20", k); end
        vecs++; if (ddr_ready !== 1'b1 || rvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL rb_idle: got ready=%b rvalid=%b want 1/0", ddr_ready, rvalid); end
        vecs++; if (cmd_addr_q.size() != 20) begin miscompares++; $display("[TB] FAIL rb_total_cmds: got %0d want 20", cmd_addr_q.size()); end
        for (int i = 0; i < cmd_addr_q.size() && i < 20; i++) begin
            vecs++; if (cmd_addr_q[i] !== 32'h0000F000 + 32'(i * 16)) begin miscompares++; $display("[TB] FAIL rb_addr%0d: got %h want %h", i, cmd_addr_q[i], 32'h0000F000 + 32'(i * 16)); end
        end
        tick();
    endtask

    task automatic test_write_burst();
        bit          wv_pat  [8] = '{1, 0, 1, 1, 0, 0, 1, 1};
        bit          rdy_pat [8] = '{1, 1, 0, 1, 1, 1, 1, 1};
        logic [31:0] exp_a   [4] = '{32'hFFFFFFF0, 32'h00000000, 32'h00000010, 32'h00000020};
        int b;
        cmd_addr_q.delete();
        awaddr = 32'hFFFFFFF0; awlen = 8'd3; awvalid = 1'b1; app_rdy = 1'b1;
        #1;
        vecs++; if (awready !== 1'b1) begin miscompares++; $display("[TB] FAIL wb_awready: got %b want 1", awready); end
        tick();
        awvalid = 1'b0;
        b = 0;
        for (int c = 0; c < 8; c++) begin
            wvalid = wv_pat[c]; app_wdf_rdy = rdy_pat[c];
            wdata = {96'h0, 32'hB000 + 32'(b)}; wstrb = 16'h00F0;
            #1;
            vecs++; if (app_cmd_en !== wv_pat[c] || app_wdf_wren !== wv_pat[c]) begin miscompares++; $display("[TB] FAIL wb_en_c%0d: got %b%b want %b", c, app_cmd_en, app_wdf_wren, wv_pat[c]); end
            vecs++; if (app_addr !== exp_a[b]) begin miscompares++; $display("[TB] FAIL wb_addr_c%0d: got %h want %h", c, app_addr, exp_a[b]); end
            vecs++; if (wready !== rdy_pat[c]) begin miscompares++; $display("[TB] FAIL wb_wready_c%0d: got %b want %b", c, wready, rdy_pat[c]); end
            vecs++; if (app_wdf_mask !== 16'h00F0) begin miscompares++; $display("[TB] FAIL wb_mask_c%0d: got %h want 00f0", c, app_wdf_mask); end
            if (wv_pat[c] && rdy_pat[c]) b++;
            tick();
        end
        wvalid = 1'b0; app_wdf_rdy = 1'b1;
        #1;
        vecs++; if (bvalid !== 1'b1) begin miscompares++; $display("[TB] FAIL wb_bvalid: got %b want 1", bvalid); end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        vecs++; if (cmd_addr_q.size() != 4) begin miscompares++; $display("[TB] FAIL wb_cmd_count: got %0d want 4", cmd_addr_q.size()); end
        for (int i = 0; i < cmd_addr_q.size() && i < 4; i++) begin
            vecs++; if (cmd_addr_q[i] !== exp_a[i]) begin miscompares++; $display("[TB] FAIL wb_cmd_addr%0d: got %h want %h", i, cmd_addr_q[i], exp_a[i]); end
        end
        tick();
    endtask

    task automatic test_calib();
        init_calib_complete = 1'b0;
        awaddr = 32'h00000300; awlen = 8'd0; awvalid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            vecs++; if (awready !== 1'b0 || ddr_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL calib_c%0d: got aw=%b ready=%b want 0/0", c, awready, ddr_ready); end
            tick();
        end
        awvalid = 1'b0; init_calib_complete = 1'b1;
        #1;
        vecs++; if (ddr_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL calib_ready: got %b want 1", ddr_ready); end
        tick();
    endtask

    task automatic test_reset_mid_read();
        araddr = 32'h00002000; arlen = 8'd7; arvalid = 1'b1; rready = 1'b0; app_rdy = 1'b1;
        tick();
        arvalid = 1'b0;
        #1;
        for (int c = 0; c < 30; c++) begin
            if (rvalid) break;
            tick(); #1;
        end
        vecs++; if (rvalid !== 1'b1) begin miscompares++; $display("[TB] FAIL rr_rvalid_timeout: got %b want 1", rvalid); end
        @(negedge clk);
        rstn = 1'b0;
        tick(); #1;
        vecs++; if (rvalid !== 1'b0 || rlast !== 1'b0) begin miscompares++; $display("[TB] FAIL rr_fifo: got rvalid=%b rlast=%b want 0/0", rvalid, rlast); end
        vecs++; if (app_cmd_en !== 1'b0 || app_cmd !== 3'b000) begin miscompares++; $display("[TB] FAIL rr_cmd: got en=%b cmd=%h want 0/0", app_cmd_en, app_cmd); end
        vecs++; if (arready !== 1'b0 || awready !== 1'b0 || wready !== 1'b0) begin miscompares++; $display("[TB] FAIL rr_readies: got %b%b%b want 000", arready, awready, wready); end
        vecs++; if (bvalid !== 1'b0 || ddr_ready !== 1'b0 || app_addr !== 32'h0) begin miscompares++; $display("[TB] FAIL rr_misc: got bvalid=%b ready=%b addr=%h want 0/0/0", bvalid, ddr_ready, app_addr); end
        @(negedge clk);
        rstn = 1'b1; rready = 1'b1;
        for (int c = 0; c < 15; c++) begin
            tick(); #1;
            vecs++; if (rvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL rr_late_data_c%0d: got rvalid=%b want 0", c, rvalid); end
        end
        vecs++; if (ddr_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL rr_ready_after: got %b want 1", ddr_ready); end
        tick();
    endtask

    initial begin
        rstn = 1'b0; init_calib_complete = 1'b1;
        awaddr = '0; awlen = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0;
        app_rdy = 1'b1; app_wdf_rdy = 1'b1;
        @(negedge clk);
        test_reset();
        test_single_write();
        test_single_read();
        test_arbitration();
        test_read_burst();
        test_write_burst();
        test_calib();
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
